// File: rtl/std_latch_pipe.sv
// std_latch_pipe: small synchronous FIFO-style elastic buffer.
// Holds up to LATCH_DEPTH payloads and presents them to the consumer in arrival order.
// i_ready, o_valid and q are all derived from registered state only, so there is
// no combinational path from either side of the handshake to the other.
module std_latch_pipe #(
  parameter int                     LATCH_WIDTH = 1,
  parameter int                     LATCH_DEPTH = 2,
  parameter logic [LATCH_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               i_valid,
  output logic                               i_ready,
  input  logic [LATCH_WIDTH-1:0]             d,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [LATCH_WIDTH-1:0]             q,
  output logic [$clog2(LATCH_DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(LATCH_DEPTH + 1);
  localparam int PTR_W = (LATCH_DEPTH > 1) ? $clog2(LATCH_DEPTH) : 1;
  // Storage is padded to a power of two so every pointer value has a slot.
  // Slots at or above LATCH_DEPTH are never addressed, because both pointers
  // wrap at LATCH_DEPTH-1, so they only ever hold RESET_VALUE.
  localparam int SLOTS = 1 << PTR_W;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LATCH_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LATCH_DEPTH);

  logic [LATCH_WIDTH-1:0] mem [0:SLOTS-1];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr_nxt;
  logic [PTR_W-1:0]       rd_ptr_nxt;
  logic                   push;
  logic                   pop;

  // Handshake outputs come from the registered occupancy only.
  assign i_ready = (count < FULL_CNT);
  assign o_valid = (count != '0);
  assign q       = mem[rd_ptr];

  // Transfers happen only where both sides agree; d never gates a transfer,
  // so an unknown payload cannot disturb the control state.
  assign push = i_valid & i_ready;
  assign pop  = o_valid & o_ready;

  // Pointer increment with explicit wrap, correct for non-power-of-two depths.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
  end

  // State update: reset beats flush, flush beats push/pop.
  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is reset here on purpose: q must show RESET_VALUE
      // after reset, and q reads the storage directly even while empty.
      for (int i = 0; i < SLOTS; i++) begin
        mem[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      // Contents are kept; only the bookkeeping is cleared.
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d;
        wr_ptr      <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_std_latch_pipe.sv
// tb_std_latch_pipe: directed self-checking bench for std_latch_pipe.
// Three instances cover depth 2 (reset value A5), depth 3 and depth 1.
module tb_std_latch_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: W=8, D=2, RESET_VALUE=8'hA5
  logic       a_flush, a_i_valid, a_i_ready, a_o_valid, a_o_ready;
  logic [7:0] a_d, a_q;
  logic [1:0] a_count;
  // Instance B: W=8, D=3, RESET_VALUE=0
  logic       b_flush, b_i_valid, b_i_ready, b_o_valid, b_o_ready;
  logic [7:0] b_d, b_q;
  logic [1:0] b_count;
  // Instance C: W=8, D=1, RESET_VALUE=0
  logic       c_flush, c_i_valid, c_i_ready, c_o_valid, c_o_ready;
  logic [7:0] c_d, c_q;
  logic [0:0] c_count;

  std_latch_pipe #(.LATCH_WIDTH(8), .LATCH_DEPTH(2), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .i_valid(a_i_valid), .i_ready(a_i_ready),
    .d(a_d), .o_valid(a_o_valid), .o_ready(a_o_ready), .q(a_q), .count(a_count));

  std_latch_pipe #(.LATCH_WIDTH(8), .LATCH_DEPTH(3), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .i_valid(b_i_valid), .i_ready(b_i_ready),
    .d(b_d), .o_valid(b_o_valid), .o_ready(b_o_ready), .q(b_q), .count(b_count));

  std_latch_pipe #(.LATCH_WIDTH(8), .LATCH_DEPTH(1), .RESET_VALUE(8'h00)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .i_valid(c_i_valid), .i_ready(c_i_ready),
    .d(c_d), .o_valid(c_o_valid), .o_ready(c_o_ready), .q(c_q), .count(c_count));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_drive(input logic iv, input logic [7:0] dv, input logic ordy, input logic fl);
    b_i_valid = iv;
    b_d       = dv;
    b_o_ready = ordy;
    b_flush   = fl;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 0; a_i_valid = 0; a_o_ready = 0; a_d = 8'h00;
    b_drive(0, 8'h00, 0, 0);
    c_flush = 0; c_i_valid = 0; c_o_ready = 0; c_d = 8'h00;

    // ---------------- Reset (instance A) ----------------
    tick();
    tick();
    reset = 1'b0;
    check("a_rst_count",   32'(a_count),   32'd0);
    check("a_rst_o_valid", 32'(a_o_valid), 32'd0);
    check("a_rst_i_ready", 32'(a_i_ready), 32'd1);
    check("a_rst_q",       32'(a_q),       32'hA5);
    check("b_rst_count",   32'(b_count),   32'd0);
    check("c_rst_i_ready", 32'(c_i_ready), 32'd1);

    // One push into A, then a reset pulse strictly between edges.
    a_i_valid = 1; a_d = 8'h3C;
    tick();
    a_i_valid = 0;
    check("a_push_count", 32'(a_count), 32'd1);
    check("a_push_q",     32'(a_q),     32'h3C);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    check("a_async_pulse_count", 32'(a_count),   32'd1);
    check("a_async_pulse_valid", 32'(a_o_valid), 32'd1);

    // ---------------- Fill and stall (instance B, D=3) ----------------
    b_drive(1, 8'h11, 0, 0); tick();
    check("b_fill1_count", 32'(b_count), 32'd1);
    check("b_fill1_q",     32'(b_q),     32'h11);
    b_drive(1, 8'h22, 0, 0); tick();
    check("b_fill2_count", 32'(b_count), 32'd2);
    b_drive(1, 8'h33, 0, 0); tick();
    check("b_full_count",   32'(b_count),   32'd3);
    check("b_full_i_ready", 32'(b_i_ready), 32'd0);
    check("b_full_q",       32'(b_q),       32'h11);
    b_drive(1, 8'h44, 0, 0); tick();
    check("b_stall_count", 32'(b_count), 32'd3);
    check("b_stall_q",     32'(b_q),     32'h11);

    // Full with simultaneous pop: 0x11 leaves, 0x44 is refused.
    b_drive(1, 8'h44, 1, 0); tick();
    check("b_fullpop_count",   32'(b_count),   32'd2);
    check("b_fullpop_i_ready", 32'(b_i_ready), 32'd1);
    check("b_fullpop_q",       32'(b_q),       32'h22);

    // Drain; 0x44 must not show up.
    b_drive(0, 8'h44, 1, 0); tick();
    check("b_drain1_q",     32'(b_q),     32'h33);
    check("b_drain1_count", 32'(b_count), 32'd1);
    tick();
    check("b_drain2_count",   32'(b_count),   32'd0);
    check("b_drain2_o_valid", 32'(b_o_valid), 32'd0);
    // Empty: q shows the slot at the read pointer (wrapped back to 0 -> 0x11).
    check("b_empty_q", 32'(b_q), 32'h11);
    // o_ready while empty must not move anything.
    tick();
    check("b_empty_pop_count", 32'(b_count), 32'd0);
    check("b_empty_pop_q",     32'(b_q),     32'h11);

    // ---------------- Streaming wrap (instance B) ----------------
    for (int k = 0; k < 10; k++) begin
      b_drive(1, 8'(k), 1, 0);
      tick();
      check($sformatf("b_stream_q%0d", k),     32'(b_q),     32'(k));
      check($sformatf("b_stream_count%0d", k), 32'(b_count), 32'd1);
    end
    b_drive(0, 8'h00, 1, 0); tick();
    check("b_stream_end_count", 32'(b_count), 32'd0);

    // ---------------- Flush versus push (instance B) ----------------
    // Pointers are both at 1 now; 0xA0 and 0xB0 land in slots 1 and 2.
    b_drive(1, 8'hA0, 0, 0); tick();
    b_drive(1, 8'hB0, 0, 0); tick();
    check("b_preflush_count", 32'(b_count), 32'd2);
    b_drive(1, 8'h55, 0, 1); tick();
    b_drive(0, 8'h00, 1, 0);
    check("b_flush_count",   32'(b_count),   32'd0);
    check("b_flush_o_valid", 32'(b_o_valid), 32'd0);
    check("b_flush_i_ready", 32'(b_i_ready), 32'd1);
    // Pointers back at 0: slot 0 last held 9 from the stream.
    check("b_flush_q", 32'(b_q), 32'h09);
    tick();
    check("b_flush_q_later", 32'(b_q), 32'h09);
    // First push after flush goes to slot 0.
    b_drive(1, 8'h66, 0, 0); tick();
    check("b_postflush_q",     32'(b_q),     32'h66);
    check("b_postflush_count", 32'(b_count), 32'd1);

    // Reset mid-stream beats a concurrent push.
    b_drive(1, 8'h77, 1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_drive(0, 8'h00, 0, 0);
    check("b_midrst_count", 32'(b_count), 32'd0);
    check("b_midrst_q",     32'(b_q),     32'h00);
    // Instance A was also reset: back to A5.
    check("a_midrst_q",     32'(a_q),     32'hA5);
    check("a_midrst_count", 32'(a_count), 32'd0);

    // ---------------- Depth-1 mode (instance C) ----------------
    // d changes every cycle; only every other value is accepted.
    check("c_d1_i_ready_init", 32'(c_i_ready), 32'd1);
    c_i_valid = 1; c_o_ready = 1;
    for (int k = 0; k < 6; k++) begin
      c_d = 8'(8'h10 * (k + 1));
      tick();
      if (k % 2 == 0) begin
        check($sformatf("c_d1_i_ready%0d", k), 32'(c_i_ready), 32'd0);
        check($sformatf("c_d1_o_valid%0d", k), 32'(c_o_valid), 32'd1);
        check($sformatf("c_d1_q%0d", k),       32'(c_q),       32'(8'h10 * (k + 1)));
      end else begin
        check($sformatf("c_d1_i_ready%0d", k), 32'(c_i_ready), 32'd1);
        check($sformatf("c_d1_o_valid%0d", k), 32'(c_o_valid), 32'd0);
      end
    end
    c_i_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
